// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the two-master sdram command-port arbiter.
package sdram_arb_pkg;

   localparam int ADDR_W_DEF = 23;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between m0 and m1 with an anti-starvation counter for m1.
module arb_pick
   import sdram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       m0_req,
   input  logic       m1_req,
   input  logic [3:0] starve_cnt,
   output owner_t     winner,
   output logic [3:0] starve_nxt
);

   // starve_nxt is only meaningful when the caller actually makes a decision
   always_comb begin
      winner     = OWN_M0;
      starve_nxt = 4'd0;
      if (m1_req && (!m0_req || starve_cnt == 4'(STARVE_LIMIT))) begin
         winner     = OWN_M1;
         starve_nxt = 4'd0;
      end else if (m1_req) begin
         starve_nxt = (starve_cnt >= 4'(STARVE_LIMIT)) ? 4'(STARVE_LIMIT)
                                                        : starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the sdram controller command port between m0 (CPU) and m1 (DMA),
// returning completion, read data and abort status to the granted requester.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clki,
   input  logic              rst_in,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [15:0]       m0_wdata,
   output logic              m0_done,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [15:0]       m1_wdata,
   output logic              m1_done,
   output logic [31:0]       rdata,
   output logic              err,
   output logic              sd_read,
   output logic              sd_write,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [15:0]       sd_wdata,
   input  logic              sd_busy,
   input  logic              sd_cack,
   input  logic              sd_ready,
   input  logic [31:0]       sd_rdata
);

   arb_state_t state, state_nxt;
   owner_t     owner, winner;
   logic       lat_we;
   logic [3:0] starve_cnt, starve_nxt;
   logic [7:0] tmo_cnt;
   logic       grant, tmo_hit, finish, take_rdata, abort;

   arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .m0_req     (m0_req),
      .m1_req     (m1_req),
      .starve_cnt (starve_cnt),
      .winner     (winner),
      .starve_nxt (starve_nxt)
   );

   assign grant   = (state == IDLE) && (m0_req || m1_req) && !sd_busy;
   assign tmo_hit = (tmo_cnt + 8'd1) == 8'(TIMEOUT);

   always_ff @(posedge clki or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   // A real completion on the last allowed cycle wins over the timeout
   always_comb begin
      state_nxt  = state;
      finish     = 1'b0;
      take_rdata = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (grant) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (sd_cack && (lat_we || sd_ready)) begin
               finish     = 1'b1;
               take_rdata = !lat_we;
               state_nxt  = IDLE;
            end else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else if (sd_cack) begin
               state_nxt = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (sd_ready) begin
               finish     = 1'b1;
               take_rdata = 1'b1;
               state_nxt  = IDLE;
            end else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clki or negedge rst_in) begin
      if (!rst_in) begin
         owner      <= OWN_M0;
         lat_we     <= 1'b0;
         sd_addr    <= '0;
         sd_wdata   <= '0;
         sd_read    <= 1'b0;
         sd_write   <= 1'b0;
         rdata      <= '0;
         m0_done    <= 1'b0;
         m1_done    <= 1'b0;
         err        <= 1'b0;
         starve_cnt <= 4'd0;
         tmo_cnt    <= 8'd0;
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         err     <= 1'b0;
         if (state == ISSUE || state == WAIT_RD) tmo_cnt <= tmo_cnt + 8'd1;
         if (grant) begin
            owner      <= winner;
            lat_we     <= (winner == OWN_M1) ? m1_we    : m0_we;
            sd_addr    <= (winner == OWN_M1) ? m1_addr  : m0_addr;
            sd_wdata   <= (winner == OWN_M1) ? m1_wdata : m0_wdata;
            sd_read    <= (winner == OWN_M1) ? !m1_we   : !m0_we;
            sd_write   <= (winner == OWN_M1) ? m1_we    : m0_we;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= 8'd0;
         end
         if (state == ISSUE && sd_cack) begin
            sd_read  <= 1'b0;
            sd_write <= 1'b0;
         end
         // Done goes only to the latched owner, never to whoever is requesting now
         if (finish || abort) begin
            sd_read  <= 1'b0;
            sd_write <= 1'b0;
            m0_done  <= (owner == OWN_M0);
            m1_done  <= (owner == OWN_M1);
         end
         if (take_rdata) rdata <= sd_rdata;
         if (abort) begin
            err   <= 1'b1;
            rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scenario bench for sdram_arbiter; expected completions are queued when stimulus is driven.
module tb_sdram_arbiter;

   localparam int AW = 23;

   logic          clki = 1'b0;
   logic          rst_in;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [15:0]   m0_wdata, m1_wdata;
   logic          sd_busy, sd_cack, sd_ready;
   logic [31:0]   sd_rdata;

   logic          m0_done, m1_done, err, sd_read, sd_write;
   logic [31:0]   rdata;
   logic [AW-1:0] sd_addr;
   logic [15:0]   sd_wdata;

   logic          t_m0_done, t_m1_done, t_err, t_sd_read, t_sd_write;
   logic [31:0]   t_rdata;
   logic [AW-1:0] t_sd_addr;
   logic [15:0]   t_sd_wdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        who;
      logic        chk_data;
      logic [31:0] data;
      logic        is_err;
   } exp_t;
   exp_t sb[$];

   always #5 clki = ~clki;

   sdram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
      .clki(clki), .rst_in(rst_in),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_done(m0_done),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_done(m1_done),
      .rdata(rdata), .err(err), .sd_read(sd_read), .sd_write(sd_write),
      .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_busy(sd_busy), .sd_cack(sd_cack),
      .sd_ready(sd_ready), .sd_rdata(sd_rdata)
   );

   sdram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4), .TIMEOUT(8)) dut_t (
      .clki(clki), .rst_in(rst_in),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_done(t_m0_done),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_done(t_m1_done),
      .rdata(t_rdata), .err(t_err), .sd_read(t_sd_read), .sd_write(t_sd_write),
      .sd_addr(t_sd_addr), .sd_wdata(t_sd_wdata), .sd_busy(sd_busy), .sd_cack(sd_cack),
      .sd_ready(sd_ready), .sd_rdata(sd_rdata)
   );

   // Inputs change and outputs are sampled 1ns after each rising edge
   task automatic tick();
      @(posedge clki);
      #1;
   endtask

   task automatic pulse_reset();
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      {m0_req, m0_we, m1_req, m1_we, sd_busy, sd_cack, sd_ready} = '0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; sd_rdata = '0;
      tick(); tick();
      checks++;
      if ({m0_done, m1_done, err, sd_read, sd_write} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {m0_done, m1_done, err, sd_read, sd_write});
      end
      checks++;
      if ({rdata, sd_addr, sd_wdata} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0", rdata, sd_addr, sd_wdata);
      end
      rst_in = 1'b1;
      tick();
   endtask

   task automatic test_m0_read();
      exp_t e;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000123;
      sb.push_back('{who: 1'b0, chk_data: 1'b1, data: 32'hDEADBEEF, is_err: 1'b0});
      tick();
      checks++;
      if (sd_read !== 1'b1 || sd_write !== 1'b0 || sd_addr !== 23'h000123) begin
         failures++;
         $display("[TB] FAIL m0_grant: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=000123", sd_read, sd_write, sd_addr);
      end
      m0_addr = 23'h000000;
      tick();
      checks++;
      if (sd_read !== 1'b1 || sd_addr !== 23'h000123) begin
         failures++;
         $display("[TB] FAIL m0_hold: got rd=%b addr=%h expected rd=1 addr=000123", sd_read, sd_addr);
      end
      tick();
      sd_cack = 1'b1;
      tick();
      sd_cack = 1'b0;
      checks++;
      if (sd_read !== 1'b0 || m0_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL m0_cack_drop: got rd=%b done=%b expected 0 0", sd_read, m0_done);
      end
      for (int i = 0; i < 4; i++) tick();
      sd_ready = 1'b1; sd_rdata = 32'hDEADBEEF;
      tick();
      sd_ready = 1'b0; sd_rdata = 32'h0;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL m0_read_sb: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         if ({m1_done, m0_done} !== (e.who ? 2'b10 : 2'b01) || rdata !== e.data || err !== e.is_err) begin
            failures++;
            $display("[TB] FAIL m0_read_done: got m1/m0=%b%b rdata=%h err=%b expected %b rdata=%h err=%b",
                     m1_done, m0_done, rdata, err, (e.who ? 2'b10 : 2'b01), e.data, e.is_err);
         end
      end
      m0_req = 1'b0;
      tick();
      checks++;
      if (m0_done !== 1'b0 || sd_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL m0_one_shot: got done=%b rd=%b expected 0 0", m0_done, sd_read);
      end
   endtask

   task automatic test_m1_write();
      exp_t e;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 23'h7FFFFF; m1_wdata = 16'hA5A5;
      sb.push_back('{who: 1'b1, chk_data: 1'b0, data: 32'h0, is_err: 1'b0});
      tick();
      m1_wdata = 16'h0000; m1_we = 1'b0; m1_addr = 23'h000001;
      tick();
      checks++;
      if (sd_write !== 1'b1 || sd_read !== 1'b0 || sd_addr !== 23'h7FFFFF || sd_wdata !== 16'hA5A5) begin
         failures++;
         $display("[TB] FAIL m1_latch: got wr=%b rd=%b addr=%h wdata=%h expected 1 0 7fffff a5a5", sd_write, sd_read, sd_addr, sd_wdata);
      end
      sd_cack = 1'b1;
      tick();
      sd_cack = 1'b0;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL m1_write_sb: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         if ({m1_done, m0_done} !== (e.who ? 2'b10 : 2'b01) || err !== e.is_err || sd_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL m1_write_done: got m1/m0=%b%b err=%b wr=%b expected %b err=%b wr=0",
                     m1_done, m0_done, err, sd_write, (e.who ? 2'b10 : 2'b01), e.is_err);
         end
      end
      m1_req = 1'b0;
      tick();
      checks++;
      if (m1_done !== 1'b0 || sd_write !== 1'b0 || sd_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL m1_after: got done=%b wr=%b rd=%b expected 0 0 0", m1_done, sd_write, sd_read);
      end
   endtask

   task automatic test_starvation();
      exp_t e;
      logic order [10];
      order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 23'h000001; m0_wdata = 16'h1111;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 23'h000002; m1_wdata = 16'h2222;
      for (int k = 0; k < 10; k++)
         sb.push_back('{who: order[k], chk_data: 1'b0, data: 32'h0, is_err: 1'b0});
      tick();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (sd_write !== 1'b1 || sd_addr !== (order[k] ? 23'h000002 : 23'h000001)) begin
            failures++;
            $display("[TB] FAIL starve_grant%0d: got wr=%b addr=%h expected wr=1 addr=%h",
                     k, sd_write, sd_addr, (order[k] ? 23'h000002 : 23'h000001));
         end
         sd_cack = 1'b1;
         tick();
         sd_cack = 1'b0;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL starve_sb%0d: got empty queue expected entry", k);
         end else begin
            e = sb.pop_front();
            if ({m1_done, m0_done} !== (e.who ? 2'b10 : 2'b01)) begin
               failures++;
               $display("[TB] FAIL starve_done%0d: got m1/m0=%b%b expected %b", k, m1_done, m0_done, (e.who ? 2'b10 : 2'b01));
            end
         end
         if (k == 9) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
         tick();
      end
      checks++;
      if (sd_write !== 1'b0 || sd_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL starve_stop: got wr=%b rd=%b expected 0 0", sd_write, sd_read);
      end
   endtask

   task automatic test_busy();
      exp_t e;
      int   seen = 0;
      sd_busy = 1'b1;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000055;
      sb.push_back('{who: 1'b0, chk_data: 1'b1, data: 32'h12345678, is_err: 1'b0});
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sd_read || sd_write) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL busy_block: got %0d command cycles expected 0", seen);
      end
      sd_busy = 1'b0;
      tick();
      checks++;
      if (sd_read !== 1'b1 || sd_addr !== 23'h000055) begin
         failures++;
         $display("[TB] FAIL busy_release: got rd=%b addr=%h expected rd=1 addr=000055", sd_read, sd_addr);
      end
      sd_cack = 1'b1; sd_ready = 1'b1; sd_rdata = 32'h12345678;
      tick();
      sd_cack = 1'b0; sd_ready = 1'b0; sd_rdata = 32'h0;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL busy_sb: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         if ({m1_done, m0_done} !== (e.who ? 2'b10 : 2'b01) || rdata !== e.data || err !== e.is_err) begin
            failures++;
            $display("[TB] FAIL cack_ready_same: got m1/m0=%b%b rdata=%h err=%b expected %b rdata=%h err=%b",
                     m1_done, m0_done, rdata, err, (e.who ? 2'b10 : 2'b01), e.data, e.is_err);
         end
      end
      m0_req = 1'b0;
      tick();
      checks++;
      if (sd_read !== 1'b0 || m0_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL busy_after: got rd=%b done=%b expected 0 0", sd_read, m0_done);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      int   early = 0;
      pulse_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000042;
      tick();
      sd_cack = 1'b1; sd_ready = 1'b1; sd_rdata = 32'hCAFEF00D;
      tick();
      sd_cack = 1'b0; sd_ready = 1'b0; sd_rdata = 32'h0;
      m0_req = 1'b0;
      checks++;
      if (t_m0_done !== 1'b1 || t_rdata !== 32'hCAFEF00D) begin
         failures++;
         $display("[TB] FAIL tmo_preload: got done=%b rdata=%h expected 1 cafef00d", t_m0_done, t_rdata);
      end
      tick();
      m0_req = 1'b1; m0_addr = 23'h000043;
      sb.push_back('{who: 1'b0, chk_data: 1'b1, data: 32'h0, is_err: 1'b1});
      tick();
      sd_cack = 1'b1;
      tick();
      sd_cack = 1'b0;
      if (t_m0_done || t_err || t_sd_read) early++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (t_m0_done || t_err || t_sd_read) early++;
      end
      checks++;
      if (early != 0) begin
         failures++;
         $display("[TB] FAIL tmo_early: got %0d bad cycles expected 0", early);
      end
      tick();
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL tmo_sb: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         if ({t_m1_done, t_m0_done} !== (e.who ? 2'b10 : 2'b01) || t_err !== e.is_err ||
             t_rdata !== e.data || t_sd_read !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_abort: got m1/m0=%b%b err=%b rdata=%h rd=%b expected %b err=%b rdata=%h rd=0",
                     t_m1_done, t_m0_done, t_err, t_rdata, t_sd_read, (e.who ? 2'b10 : 2'b01), e.is_err, e.data);
         end
      end
      m0_req = 1'b0;
      tick();
      checks++;
      if (t_err !== 1'b0 || t_m0_done !== 1'b0 || t_sd_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL tmo_one_shot: got err=%b done=%b rd=%b expected 0 0 0", t_err, t_m0_done, t_sd_read);
      end
      sd_ready = 1'b1; sd_rdata = 32'hFFFFFFFF;
      tick();
      sd_ready = 1'b0; sd_rdata = 32'h0;
      checks++;
      if (t_rdata !== 32'h0 || t_m0_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_ready_ignored: got rdata=%h done=%b expected 0 0", t_rdata, t_m0_done);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   late = 0;
      pulse_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000010;
      sb.push_back('{who: 1'b0, chk_data: 1'b1, data: 32'h0BADF00D, is_err: 1'b0});
      tick();
      sd_cack = 1'b1; sd_ready = 1'b1; sd_rdata = 32'h0BADF00D;
      tick();
      sd_cack = 1'b0; sd_ready = 1'b0; sd_rdata = 32'h0;
      m0_req = 1'b0;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL rmid_sb: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         if (m0_done !== 1'b1 || rdata !== e.data) begin
            failures++;
            $display("[TB] FAIL rmid_preload: got done=%b rdata=%h expected 1 %h", m0_done, rdata, e.data);
         end
      end
      tick();
      m0_req = 1'b1; m0_addr = 23'h000321;
      tick();
      sd_cack = 1'b1;
      tick();
      sd_cack = 1'b0;
      tick();
      rst_in = 1'b0;
      m0_req = 1'b0;
      #2;
      checks++;
      if ({m0_done, m1_done, err, sd_read, sd_write} !== 5'b0 || rdata !== 32'h0 || sd_addr !== '0 || sd_wdata !== '0) begin
         failures++;
         $display("[TB] FAIL rmid_async: got ctrl=%b rdata=%h addr=%h wdata=%h expected all 0",
                  {m0_done, m1_done, err, sd_read, sd_write}, rdata, sd_addr, sd_wdata);
      end
      tick();
      rst_in = 1'b1;
      tick();
      sd_ready = 1'b1; sd_rdata = 32'hFFFFFFFF;
      tick();
      sd_ready = 1'b0; sd_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         if (m0_done || m1_done || err || sd_read || rdata != 32'h0) late++;
         tick();
      end
      checks++;
      if (late != 0) begin
         failures++;
         $display("[TB] FAIL rmid_late_ready: got %0d bad cycles expected 0", late);
      end
   endtask

   initial begin
      test_reset();
      test_m0_read();
      test_m1_write();
      test_starvation();
      test_busy();
      test_timeout();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL sb_drain: got %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single sdram controller command port between two requesters: m0 (CPU data/instruction path) and m1 (block-transfer DMA feeding VGA/SPI buffers).
- Sits between the hw memory-switching logic and the sdram controller.
- Handles latching of address, data and direction, command issue, and accept/read-data handshakes.
- Returns completion and read data to the granted requester only.

Parameters:
- ADDR_W, 23, sdram word address width.
- STARVE_LIMIT, 4, m1 gets forced priority after this many consecutive m0 wins while m1 was requesting (1..15).
- TIMEOUT, 255, max clki cycles in ISSUE or WAIT_RD before abort with error (1..255).

Ports:
- clki  in  1  clock; all state on rising edge.
- rst_in  in  1  reset; asynchronous assert, active-low.
- m0_req  in  1  m0 request; level, held until m0_done.
- m0_we  in  1  m0 direction: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  m0 word address.
- m0_wdata  in  16  m0 write data.
- m0_done  out  1  one-cycle completion pulse to m0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_done  same as m0, for m1.
- rdata  out  32  read data; valid in the cycle *_done pulses for a read.
- err  out  1  one-cycle pulse, same cycle as the *_done of an aborted access.
- sd_read  out  1  sdram read command; level.
- sd_write  out  1  sdram write command; level.
- sd_addr  out  ADDR_W  latched address.
- sd_wdata  out  16  latched write data.
- sd_busy  in  1  controller busy; no new command may be raised while high.
- sd_cack  in  1  command accepted; one-cycle pulse.
- sd_ready  in  1  read data valid on sd_rdata; one-cycle pulse.
- sd_rdata  in  32  controller read data.

Behaviour:
- Reset (rst_in low), all asynchronous:
  - state = IDLE.
  - All outputs 0, including rdata, sd_addr and sd_wdata.
  - starve_cnt = 0, tmo_cnt = 0.
- IDLE:
  - Transition occurs when (m0_req | m1_req) & ~sd_busy.
  - Winner is m1 if m1_req & (~m0_req | starve_cnt == STARVE_LIMIT); otherwise m0.
  - Latch owner, we, addr and wdata into sd_* registers; go to ISSUE.
  - sd_read/sd_write rise in the cycle after the decision (1-cycle grant latency).
- starve_cnt:
  - Increments when m0 wins while m1_req is high, saturating at STARVE_LIMIT.
  - Clears when m1 wins, or on a decision made while m1_req is low.
- ISSUE:
  - Hold sd_read = ~we, sd_write = we until sd_cack.
  - On sd_cack, drop the command the same edge.
  - Write: pulse owner's done, go IDLE.
  - Read: go WAIT_RD.
- WAIT_RD:
  - On sd_ready, capture sd_rdata into rdata, pulse owner's done, go IDLE.
  - sd_ready is ignored in every other state.
- Simultaneous sd_cack and sd_ready in ISSUE for a read:
  - Treat as complete.
  - Capture rdata, pulse done, go IDLE.
- Timeout:
  - tmo_cnt clears on entry to ISSUE, counts each cycle in ISSUE and WAIT_RD.
  - On reaching TIMEOUT: drop commands, pulse owner's done and err, rdata = 0, go IDLE.
- Back-to-back:
  - IDLE may re-arbitrate in the cycle after done.
  - Requesters must deassert req in the done cycle or a new access begins.
- Request withdrawn before grant: ignored, no done.
- Request withdrawn after grant: access completes, done still pulses.
- Latched addr, we and wdata are immune to requester changes after grant.
- Only the owner's done ever pulses; at most one done per cycle.
- Reset mid-access: everything returns to reset values immediately; the in-flight command is dropped and no done is issued.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT_RD=2'd2;
  - owner encoding OWN_M0=1'b0, OWN_M1=1'b1;
  - default ADDR_W.
- Sub-module arb_pick: combinational winner select from m0_req, m1_req and starve_cnt, plus starve_cnt update.
- Everything else stays in sdram_arbiter.

Test Plan:
- m0 read addr 0x000123, controller returns cack after 2 cycles and ready with 0xDEADBEEF after 5 more -> sd_read high exactly until cack, m0_done one cycle with rdata=0xDEADBEEF, m1_done stays 0.
- m1 write addr 0x7FFFFF, wdata 0xA5A5, with m0 idle -> sd_write, sd_addr=0x7FFFFF, sd_wdata=0xA5A5 held until cack; m1_done in the cycle after cack, no err.
- m0 and m1 requesting continuously, STARVE_LIMIT=4, instant cack writes -> grant order m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
- sd_busy high for 10 cycles with m0_req asserted -> no sd_read/sd_write during busy; command rises 1 cycle after busy falls.
- Read with cack but no ready, TIMEOUT=8 -> after 8 cycles in ISSUE/WAIT_RD: m0_done and err pulse together, rdata=0, sd_read low, state IDLE.
- rst_in low mid-WAIT_RD, then a late sd_ready after release -> all outputs 0 at once, no done pulse, late sd_ready ignored.
